// File: rtl/hazard_stall_controller.sv
// Hazard and stall controller for the 5-stage MIPS pipeline (branches resolve in ID).
// Drives PC/IF-ID write enables, ID/EX bubble and IF/ID flush; counts stall and flush cycles.
module hazard_stall_controller #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchTaken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] IDEX_Dst,
    input  logic             EXMEM_MemRead,
    input  logic [REG_W-1:0] EXMEM_Dst,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       rs_ex_match, rt_ex_match, rs_mem_match, rt_mem_match;
    logic       ex_match, mem_match;
    logic       load_ex_hit, alu_ex_hit, load_mem_hit;
    logic [1:0] stall_len;

    // Source matching; $0 is hardwired zero and never creates a dependency.
    always_comb begin
        rs_ex_match  = ID_UsesRs && (ID_Rs != '0) && (ID_Rs == IDEX_Dst);
        rt_ex_match  = ID_UsesRt && (ID_Rt != '0) && (ID_Rt == IDEX_Dst);
        rs_mem_match = ID_UsesRs && (ID_Rs != '0) && (ID_Rs == EXMEM_Dst);
        rt_mem_match = ID_UsesRt && (ID_Rt != '0) && (ID_Rt == EXMEM_Dst);
        ex_match     = rs_ex_match || rt_ex_match;
        mem_match    = rs_mem_match || rt_mem_match;
    end

    // Stall length: max over load-use, ALU-to-branch and MEM-load-to-branch rules.
    always_comb begin
        load_ex_hit  = IDEX_MemRead && ex_match;
        alu_ex_hit   = IDEX_RegWrite && !IDEX_MemRead && ex_match && ID_IsBranch;
        load_mem_hit = EXMEM_MemRead && mem_match && ID_IsBranch;
        stall_len    = 2'd0;
        if (load_ex_hit && ID_IsBranch) begin
            stall_len = 2'd2;
        end else if (load_ex_hit || alu_ex_hit || load_mem_hit) begin
            stall_len = 2'd1;
        end
    end

    // Next state and Mealy outputs; reset forces the free-running pattern.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        if (Reset) begin
            state_d = RUN;
            rem_d   = 2'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stall_len != 2'd0) begin
                        // An unresolved branch waiting on operands must not flush.
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                        if (stall_len == 2'd2) begin
                            state_d = STALL;
                            rem_d   = 2'd1;
                        end
                    end else begin
                        IFIDFlush = ID_BranchTaken;
                    end
                end
                STALL: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                    if (rem_q <= 2'd1) begin
                        rem_d   = 2'd0;
                        state_d = RUN;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!PCWrite && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (IFIDFlush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        state_q     <= state_d;
        rem_q       <= rem_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (CNT_W=4 to reach saturation quickly).
module tb_hazard_stall_controller;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic [REG_W-1:0] ID_Rs, ID_Rt, IDEX_Dst, EXMEM_Dst;
    logic             ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken;
    logic             IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
    logic             PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    int checks   = 0;
    int failures = 0;

    logic [3:0] outs;
    assign outs = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};

    localparam logic [3:0] RUN_OUT   = 4'b1100;
    localparam logic [3:0] STALL_OUT = 4'b0010;
    localparam logic [3:0] FLUSH_OUT = 4'b1101;

    hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_Dst(IDEX_Dst),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Dst(EXMEM_Dst),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        ID_Rs = '0; ID_Rt = '0; IDEX_Dst = '0; EXMEM_Dst = '0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0; ID_BranchTaken = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; EXMEM_MemRead = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        clear_inputs();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        clear_inputs();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        ID_IsBranch = 1'b1; ID_BranchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs, RUN_OUT);
        end
        tick();
        checks++;
        if (StallCycles !== 4'd0 || FlushCount !== 4'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCycles, FlushCount);
        end
        Reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        #1;
        checks++;
        if (outs !== STALL_OUT) begin
            failures++;
            $display("FAIL load_use_stall: got %b expected %b", outs, STALL_OUT);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs !== RUN_OUT || StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL load_use_release: got %b cnt=%0d expected %b cnt=1", outs, StallCycles, RUN_OUT);
        end
        tick();
    endtask

    task automatic test_load_branch();
        apply_reset();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_IsBranch = 1'b1;
        #1;
        checks++;
        if (outs !== STALL_OUT) begin
            failures++;
            $display("FAIL load_branch_stall1: got %b expected %b", outs, STALL_OUT);
        end
        tick();
        // Inside STALL every input is don't-care.
        ID_Rs = 5'($urandom); ID_Rt = 5'($urandom); IDEX_Dst = 5'($urandom); EXMEM_Dst = 5'($urandom);
        ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom); ID_IsBranch = 1'($urandom);
        ID_BranchTaken = 1'b1; IDEX_MemRead = 1'($urandom); IDEX_RegWrite = 1'($urandom);
        EXMEM_MemRead = 1'($urandom);
        #1;
        checks++;
        if (outs !== STALL_OUT) begin
            failures++;
            $display("FAIL load_branch_stall2: got %b expected %b", outs, STALL_OUT);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs !== RUN_OUT || StallCycles !== 4'd2) begin
            failures++;
            $display("FAIL load_branch_release: got %b cnt=%0d expected %b cnt=2", outs, StallCycles, RUN_OUT);
        end
        tick();
    endtask

    task automatic test_alu_branch();
        apply_reset();
        IDEX_RegWrite = 1'b1; IDEX_Dst = 5'd3; ID_Rs = 5'd3; ID_UsesRs = 1'b1;
        ID_IsBranch = 1'b1; ID_BranchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== STALL_OUT) begin
            failures++;
            $display("FAIL alu_branch_stall: got %b expected %b", outs, STALL_OUT);
        end
        tick();
        IDEX_RegWrite = 1'b0;
        #1;
        checks++;
        if (outs !== FLUSH_OUT) begin
            failures++;
            $display("FAIL alu_branch_flush: got %b expected %b", outs, FLUSH_OUT);
        end
        tick();
        clear_inputs();
        checks++;
        if (StallCycles !== 4'd1 || FlushCount !== 4'd1) begin
            failures++;
            $display("FAIL alu_branch_counts: got %0d/%0d expected 1/1", StallCycles, FlushCount);
        end
    endtask

    task automatic test_mem_load_branch();
        apply_reset();
        EXMEM_MemRead = 1'b1; EXMEM_Dst = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b1; ID_IsBranch = 1'b1;
        #1;
        checks++;
        if (outs !== STALL_OUT) begin
            failures++;
            $display("FAIL mem_load_branch_stall: got %b expected %b", outs, STALL_OUT);
        end
        tick();
        ID_IsBranch = 1'b0;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL mem_load_nonbranch: got %b expected %b", outs, RUN_OUT);
        end
        clear_inputs();
        IDEX_RegWrite = 1'b1; IDEX_Dst = 5'd7; ID_Rs = 5'd7; ID_UsesRs = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL alu_nonbranch: got %b expected %b", outs, RUN_OUT);
        end
        tick();
        clear_inputs();
        checks++;
        if (StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL mem_load_count: got %0d expected 1", StallCycles);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1; ID_IsBranch = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL zero_reg: got %b expected %b", outs, RUN_OUT);
        end
        tick();
        IDEX_Dst = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b0;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL unused_rs: got %b expected %b", outs, RUN_OUT);
        end
        tick();
        clear_inputs();
        checks++;
        if (StallCycles !== 4'd0) begin
            failures++;
            $display("FAIL zero_reg_count: got %0d expected 0", StallCycles);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_IsBranch = 1'b1;
        tick();
        Reset = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_OUT) begin
            failures++;
            $display("FAIL reset_in_stall_outputs: got %b expected %b", outs, RUN_OUT);
        end
        tick();
        Reset = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (outs !== RUN_OUT || StallCycles !== 4'd0 || FlushCount !== 4'd0) begin
            failures++;
            $display("FAIL reset_in_stall_after: got %b cnt=%0d/%0d expected %b cnt=0/0",
                     outs, StallCycles, FlushCount, RUN_OUT);
        end
        tick();
        checks++;
        if (StallCycles !== 4'd0) begin
            failures++;
            $display("FAIL reset_in_stall_count: got %0d expected 0", StallCycles);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        IDEX_MemRead = 1'b1; IDEX_Dst = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (StallCycles !== 4'd15) begin
            failures++;
            $display("FAIL stall_count_15: got %0d expected 15", StallCycles);
        end
        tick();
        checks++;
        if (StallCycles !== 4'd15) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected 15", StallCycles);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_mem_load_branch();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
